text_row_fetcher: RTL and testbench

//  Text-mode glyph fetcher that feeds the 16-bit pixel_row word consumed by the VGA timing/serialiser stage.

---
 rtl/text_pkg.sv | 31 +++
 rtl/text_row_fetcher.sv | 159 +++++++++++++++
 tb/tb_text_row_fetcher.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/text_pkg.sv
// ---------------------------------------------------------------------------
// text_pkg
// Shared constants and record types for the text-mode glyph fetcher.
// The screen is 800x600 pixels, split into 50 columns x 30 rows of
// 16x20 pixel character cells. Line and frame totals match the 40 MHz
// VGA timing generator that drives the fetcher.
// ---------------------------------------------------------------------------
package text_pkg;

    localparam int COLS        = 50;
    localparam int ROWS        = 30;
    localparam int FONT_H      = 20;
    localparam int H_TOTAL     = 1058;
    localparam int V_TOTAL     = 628;
    localparam int PREFETCH_HL = H_TOTAL - 3;

    // One character-buffer entry: inverse-video flag above a 7-bit glyph code.
    typedef struct packed {
        logic       inv;
        logic [6:0] glyph;
    } vram_word_t;

    // One slot of the fetch pipeline.
    typedef struct packed {
        logic       valid;
        logic       blank;
        logic       inv;
        logic [4:0] line;
    } fetch_stage_t;

endpackage

// File: rtl/text_row_fetcher.sv
// ---------------------------------------------------------------------------
// text_row_fetcher
// Text-mode glyph fetcher feeding the 16-bit pixel_row word of the VGA
// serialiser. Each request from the serialiser (newData) or the per-line
// first-cell prefetch starts a 3-clock pipeline:
//   VRAM read -> font ROM read -> pixel_row load.
// The new word is valid exactly at the start of the next 16-pixel cell.
//
// Ports
//   CLK_VGA          in   pixel clock
//   reset            in   synchronous, active-high reset
//   newData          in   next cell word needed 3 clocks later
//   end_of_line      in   last clock of each line
//   end_of_frame     in   last clock of the frame (with end_of_line)
//   horizontal_line  in   serialiser column counter
//   vertical_line    in   serialiser line counter
//   vram_addr        out  character-buffer address, row*COLS+col
//   vram_rdata       in   {inverse, glyph[6:0]}, one clock after address
//   font_addr        out  {glyph, glyph_line}
//   font_rdata       in   glyph slice, MSB is the leftmost pixel
//   pixel_row        out  word presented to the serialiser
// ---------------------------------------------------------------------------
module text_row_fetcher
    import text_pkg::*;
(
    input  logic        CLK_VGA,
    input  logic        reset,
    input  logic        newData,
    input  logic        end_of_line,
    input  logic        end_of_frame,
    input  logic [10:0] horizontal_line,
    input  logic [9:0]  vertical_line,
    output logic [10:0] vram_addr,
    input  logic [7:0]  vram_rdata,
    output logic [11:0] font_addr,
    input  logic [15:0] font_rdata,
    output logic [15:0] pixel_row
);

    // Line/frame position of the line currently on screen.
    logic [4:0]   disp_line;
    logic [4:0]   disp_row;
    logic [10:0]  disp_base;

    // Position of the next cell to be fetched.
    logic [5:0]   fetch_col;
    logic [10:0]  fetch_addr;
    logic [4:0]   fetch_line;
    logic [4:0]   fetch_row;

    // Where the display counters land at the coming end_of_line.
    logic [4:0]   next_line;
    logic [4:0]   next_row;
    logic [10:0]  next_base;

    logic         trigger;
    logic         load_next;
    logic         cell_blank;
    vram_word_t   vword;
    fetch_stage_t s1;
    fetch_stage_t s2;

    // s1.inv and s2.line keep both stages the same record shape but are
    // not consumed downstream.
    logic         unused_stage_bits;

    assign unused_stage_bits = ^{s1.inv, s2.line};

    assign trigger    = newData || (horizontal_line == 11'(PREFETCH_HL));
    assign load_next  = (horizontal_line == 11'(PREFETCH_HL - 1));
    assign cell_blank = (fetch_col >= 6'(COLS)) || (fetch_row >= 5'(ROWS));

    assign vword      = vram_word_t'(vram_rdata);
    assign vram_addr  = fetch_addr;
    assign font_addr  = {vword.glyph, s1.line};

    // Next-line position: each text row is FONT_H scan lines tall, so the
    // row base steps by COLS instead of being multiplied out.
    always_comb begin
        next_line = disp_line + 5'd1;
        next_row  = disp_row;
        next_base = disp_base;
        if (disp_line == 5'(FONT_H - 1)) begin
            next_line = '0;
            next_row  = disp_row + 5'd1;
            next_base = disp_base + 11'(COLS);
        end
    end

    // Display counters follow the serialiser's line strobes.
    always_ff @(posedge CLK_VGA) begin
        if (reset) begin
            disp_line <= '0;
            disp_row  <= '0;
            disp_base <= '0;
        end else if (end_of_line) begin
            if (end_of_frame) begin
                disp_line <= '0;
                disp_row  <= '0;
                disp_base <= '0;
            end else begin
                disp_line <= next_line;
                disp_row  <= next_row;
                disp_base <= next_base;
            end
        end
    end

    // Fetch pointers are loaded one clock before the first-cell prefetch so
    // that it already addresses the coming line; the last frame line loads
    // the top of the screen. Every trigger then steps to the next cell.
    always_ff @(posedge CLK_VGA) begin
        if (reset) begin
            fetch_col  <= '0;
            fetch_addr <= '0;
            fetch_line <= '0;
            fetch_row  <= '0;
        end else if (load_next) begin
            fetch_col <= '0;
            if (vertical_line == 10'(V_TOTAL - 1)) begin
                fetch_addr <= '0;
                fetch_line <= '0;
                fetch_row  <= '0;
            end else begin
                fetch_addr <= next_base;
                fetch_line <= next_line;
                fetch_row  <= next_row;
            end
        end else if (trigger) begin
            fetch_col  <= fetch_col + 6'd1;
            fetch_addr <= fetch_addr + 11'd1;
        end
    end

    // Three-stage fetch pipeline. Blank cells still read VRAM and the font
    // ROM; their data is simply replaced by zero at the load stage.
    always_ff @(posedge CLK_VGA) begin
        if (reset) begin
            s1        <= '0;
            s2        <= '0;
            pixel_row <= '0;
        end else begin
            s1.valid <= trigger;
            s1.blank <= cell_blank;
            s1.inv   <= 1'b0;
            s1.line  <= fetch_line;

            s2.valid <= s1.valid;
            s2.blank <= s1.blank;
            s2.inv   <= vword.inv;
            s2.line  <= s1.line;

            if (s2.valid) begin
                pixel_row <= s2.blank ? 16'h0000 : (font_rdata ^ {16{s2.inv}});
            end
        end
    end

endmodule

// File: tb/tb_text_row_fetcher.sv
// ---------------------------------------------------------------------------
// tb_text_row_fetcher
// Directed bench for text_row_fetcher. Drives the serialiser strobes
// directly (full lines where cell timing matters, 4-clock short lines to
// walk the display counters) and models VRAM and font ROM as 1-clock
// synchronous memories.
// ---------------------------------------------------------------------------
module tb_text_row_fetcher;

    logic        CLK_VGA = 1'b0;
    logic        reset;
    logic        newData;
    logic        end_of_line;
    logic        end_of_frame;
    logic [10:0] horizontal_line;
    logic [9:0]  vertical_line;
    logic [10:0] vram_addr;
    logic [7:0]  vram_rdata;
    logic [11:0] font_addr;
    logic [15:0] font_rdata;
    logic [15:0] pixel_row;

    logic [7:0]  vram [0:2047];
    logic [15:0] font [0:4095];

    int checks = 0;
    int fails  = 0;

    typedef struct {
        int          col;
        logic [7:0]  vram_byte;
        logic [15:0] font_word;
        logic [15:0] expected;
    } cell_vec_t;

    cell_vec_t   vecs [7];
    logic [15:0] exp_cell [0:50];

    text_row_fetcher dut (
        .CLK_VGA         (CLK_VGA),
        .reset           (reset),
        .newData         (newData),
        .end_of_line     (end_of_line),
        .end_of_frame    (end_of_frame),
        .horizontal_line (horizontal_line),
        .vertical_line   (vertical_line),
        .vram_addr       (vram_addr),
        .vram_rdata      (vram_rdata),
        .font_addr       (font_addr),
        .font_rdata      (font_rdata),
        .pixel_row       (pixel_row)
    );

    always #5 CLK_VGA = ~CLK_VGA;

    // Synchronous character buffer and font ROM.
    always @(posedge CLK_VGA) begin
        vram_rdata <= vram[vram_addr];
        font_rdata <= font[font_addr];
    end

    task automatic check_output(input string name, input logic [15:0] actual,
                                input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge CLK_VGA);
        #1;
    endtask

    // Present one clock of serialiser state; newData follows the real
    // serialiser, three clocks ahead of each cell boundary after cell 0.
    task automatic apply_stimulus(input int hl, input int vl);
        horizontal_line = 11'(hl);
        vertical_line   = 10'(vl);
        newData         = ((hl % 16) == 13) && (hl <= 797);
        end_of_line     = (hl == 1057);
        end_of_frame    = (hl == 1057) && (vl == 627);
        #1;
    endtask

    task automatic run_short_line(input int vl);
        for (int hl = 1054; hl < 1058; hl++) begin
            apply_stimulus(hl, vl);
            step();
        end
    endtask

    // One complete line with cell-boundary and request-address checks.
    task automatic run_full_line(input int vl, input int cell_base,
                                 input int pref_addr, input int pref_font);
        for (int hl = 0; hl < 1058; hl++) begin
            apply_stimulus(hl, vl);
            if ((hl % 16) == 0 && hl <= 800)
                check_output($sformatf("v%0d_cell%0d_start", vl, hl / 16),
                             pixel_row, exp_cell[hl / 16]);
            if ((hl % 16) == 15 && hl < 800)
                check_output($sformatf("v%0d_cell%0d_hold", vl, hl / 16),
                             pixel_row, exp_cell[hl / 16]);
            if (newData)
                check_output($sformatf("v%0d_req%0d_addr", vl, (hl + 3) / 16),
                             16'(vram_addr), 16'(cell_base + (hl + 3) / 16));
            if (hl == 1055)
                check_output($sformatf("v%0d_prefetch_addr", vl),
                             16'(vram_addr), 16'(pref_addr));
            if (hl == 1056)
                check_output($sformatf("v%0d_prefetch_font", vl),
                             16'(font_addr), 16'(pref_font));
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) vram[i] = 8'h00;
        for (int i = 0; i < 4096; i++) font[i] = 16'h0000;

        // Row 0 / line 0 cells; col 50 is the blank 50th request and its
        // memory data must never reach pixel_row.
        vecs[0] = '{0,  8'h41, 16'hF00F, 16'hF00F};
        vecs[1] = '{1,  8'h42, 16'h1234, 16'h1234};
        vecs[2] = '{2,  8'hC1, 16'hF00F, 16'h0FF0};
        vecs[3] = '{3,  8'hC3, 16'h1818, 16'hE7E7};
        vecs[4] = '{5,  8'h80, 16'h0000, 16'hFFFF};
        vecs[5] = '{49, 8'h7F, 16'hABCD, 16'hABCD};
        vecs[6] = '{50, 8'h44, 16'h5A5A, 16'h0000};

        for (int k = 0; k <= 50; k++) exp_cell[k] = 16'h0000;
        for (int i = 0; i < 7; i++) begin
            logic [7:0] b;
            b = vecs[i].vram_byte;
            vram[vecs[i].col]   = b;
            font[{b[6:0], 5'd0}] = vecs[i].font_word;
            exp_cell[vecs[i].col] = vecs[i].expected;
        end
        // Row 29 line 19 cell 0, and non-zero data behind the blank row 30.
        vram[1450] = 8'h41;
        font[{7'h41, 5'd19}] = 16'hFFFF;
        vram[1500] = 8'h41;
        vram[1501] = 8'h41;

        // Reset, then no load while there is no trigger.
        reset = 1'b1;
        apply_stimulus(500, 300);
        step();
        step();
        check_output("reset_pixel_row", pixel_row, 16'h0000);
        check_output("reset_vram_addr", 16'(vram_addr), 16'h0000);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(500, 300);
            step();
            check_output($sformatf("idle_no_load%0d", i), pixel_row, 16'h0000);
        end

        // Last frame line: first-cell prefetch of the top of the screen.
        apply_stimulus(1054, 627); step();
        apply_stimulus(1055, 627);
        check_output("wrap0_prefetch_addr", 16'(vram_addr), 16'h0000);
        step();
        apply_stimulus(1056, 627);
        check_output("wrap0_font_addr", 16'(font_addr), 16'h0820);
        step();
        apply_stimulus(1057, 627); step();

        // Line 0: every cell, the blank 50th request, prefetch of line 1.
        run_full_line(0, 0, 0, 12'h821);

        // Walk to line 19 of row 0, then step into row 1.
        for (int v = 1; v <= 18; v++) run_short_line(v);
        apply_stimulus(1054, 19); step();
        apply_stimulus(1055, 19);
        check_output("row_step_addr", 16'(vram_addr), 16'd50);
        step();
        apply_stimulus(1056, 19);
        check_output("row_step_font", 16'(font_addr), 16'h0880);
        step();
        apply_stimulus(1057, 19); step();
        apply_stimulus(0, 20);
        check_output("row1_cell0", pixel_row, 16'h5A5A);
        step();

        // Walk to the last visible line and into the blank row.
        for (int v = 20; v <= 598; v++) run_short_line(v);
        apply_stimulus(1054, 599);
        check_output("row29_line19_cell0", pixel_row, 16'hFFFF);
        step();
        apply_stimulus(1055, 599);
        check_output("blank_row_addr", 16'(vram_addr), 16'd1500);
        step();
        apply_stimulus(1056, 599); step();
        apply_stimulus(1057, 599); step();
        for (int k = 0; k <= 50; k++) exp_cell[k] = 16'h0000;
        run_full_line(600, 1500, 1500, 12'h821);

        // Frame wrap back to address 0.
        for (int v = 601; v <= 626; v++) run_short_line(v);
        apply_stimulus(1054, 627); step();
        apply_stimulus(1055, 627);
        check_output("wrap_prefetch_addr", 16'(vram_addr), 16'h0000);
        step();
        apply_stimulus(1056, 627);
        check_output("wrap_font_addr", 16'(font_addr), 16'h0820);
        step();
        apply_stimulus(1057, 627); step();
        apply_stimulus(0, 0);
        check_output("wrap_pixel_row", pixel_row, 16'hF00F);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
